// File: rtl/ham_secded_pipe_if.sv
// Bus bundle for the SECDED decoder pipeline: input and output handshakes,
// decoded result fields and the error-counter interface.
interface ham_secded_pipe_if #(
    parameter int P     = 4,
    parameter int CNT_W = 16
);
    localparam int N = 1 << P;
    localparam int K = N - 1 - P;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     code_in;
    logic             out_valid;
    logic             out_ready;
    logic [K-1:0]     data_out;
    logic [P-1:0]     syndrome;
    logic             corrected;
    logic             uncorrectable;
    logic             clear_counts;
    logic [CNT_W-1:0] corr_count;
    logic [CNT_W-1:0] uncorr_count;

    // Producer/consumer side that drives codewords and takes results
    modport master (
        output in_valid, code_in, out_ready, clear_counts,
        input  in_ready, out_valid, data_out, syndrome, corrected,
               uncorrectable, corr_count, uncorr_count
    );

    // Decoder side
    modport slave (
        input  in_valid, code_in, out_ready, clear_counts,
        output in_ready, out_valid, data_out, syndrome, corrected,
               uncorrectable, corr_count, uncorr_count
    );
endinterface

// File: rtl/ham_secded_pipe.sv
// Extended-Hamming SECDED decoder for 2^P-bit codewords. Stage 1 captures the
// word with its syndrome and overall parity; stage 2 corrects, extracts the
// data bits and classifies the error. Elastic valid/ready on both sides, plus
// saturating counters of corrected and uncorrectable words.
module ham_secded_pipe #(
    parameter int P     = 4,
    parameter int CNT_W = 16
) (
    input logic              clock,
    input logic              reset,
    ham_secded_pipe_if.slave bus
);
    localparam int N  = 1 << P;
    localparam int K  = N - 1 - P;
    localparam int KW = $clog2(K);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // XOR of the indices of all set bits in Hamming positions 1..N-1
    function automatic logic [P-1:0] calc_syn(input logic [N-1:0] c);
        logic [P-1:0] s;
        s = '0;
        for (int i = 1; i < N; i++) begin
            if (c[i[P-1:0]]) s = s ^ i[P-1:0];
        end
        return s;
    endfunction

    // Gather the non-power-of-two positions in ascending order
    function automatic logic [K-1:0] extract(input logic [N-1:0] c);
        logic [K-1:0]  d;
        logic [KW-1:0] j;
        d = '0;
        j = '0;
        for (int i = 3; i < N; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = c[i[P-1:0]];
                j    = j + KW'(1);
            end
        end
        return d;
    endfunction

    logic             vld_p1_q, vld_p2_q;
    logic [N-1:0]     code_p1_q;
    logic [P-1:0]     syn_p1_q;
    logic             par_p1_q;

    logic [K-1:0]     data_p2_q, data_p2_d;
    logic [P-1:0]     syn_p2_q;
    logic             corr_p2_q, corr_p2_d;
    logic             unc_p2_q, unc_p2_d;
    logic [N-1:0]     code_fix;

    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] unc_cnt_q, unc_cnt_d;

    logic             in_ready;
    logic             load_p2;
    logic             accept;
    logic             out_xfer;

    assign load_p2  = !vld_p2_q || bus.out_ready;
    assign in_ready = !vld_p1_q || !vld_p2_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign out_xfer = vld_p2_q && bus.out_ready;

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = vld_p2_q;
    assign bus.data_out      = data_p2_q;
    assign bus.syndrome      = syn_p2_q;
    assign bus.corrected     = corr_p2_q;
    assign bus.uncorrectable = unc_p2_q;
    assign bus.corr_count    = corr_cnt_q;
    assign bus.uncorr_count  = unc_cnt_q;

    // ---- stage 1: capture codeword, syndrome and overall parity ----
    // Stage 1 payload; only meaningful while vld_p1_q is set, so it needs no reset
    always_ff @(posedge clock) begin
        if (accept) begin
            code_p1_q <= bus.code_in;
            syn_p1_q  <= calc_syn(bus.code_in);
            par_p1_q  <= ^bus.code_in;
        end
    end

    // ---- stage 2: correct, extract and classify ----
    // With odd parity the single bad bit is at index s (s==0 means bit 0, which
    // extraction ignores), so one unconditional flip covers both cases
    always_comb begin
        code_fix = code_p1_q;
        if (par_p1_q) code_fix[syn_p1_q] = ~code_fix[syn_p1_q];
        data_p2_d = extract(code_fix);
        corr_p2_d = par_p1_q;
        unc_p2_d  = (syn_p1_q != '0) && !par_p1_q;
    end

    // Valid flags of both stages; stage 1 refills on accept, drains when stage 2 loads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            if (accept)       vld_p1_q <= 1'b1;
            else if (load_p2) vld_p1_q <= 1'b0;
            if (load_p2)      vld_p2_q <= vld_p1_q;
        end
    end

    // Output registers hold their value whenever stage 2 is stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_p2_q <= '0;
            syn_p2_q  <= '0;
            corr_p2_q <= 1'b0;
            unc_p2_q  <= 1'b0;
        end else if (load_p2 && vld_p1_q) begin
            data_p2_q <= data_p2_d;
            syn_p2_q  <= syn_p1_q;
            corr_p2_q <= corr_p2_d;
            unc_p2_q  <= unc_p2_d;
        end
    end

    // Counter next state: clear wins over a same-cycle increment; saturate at max
    always_comb begin
        corr_cnt_d = corr_cnt_q;
        unc_cnt_d  = unc_cnt_q;
        if (bus.clear_counts) begin
            corr_cnt_d = '0;
            unc_cnt_d  = '0;
        end else if (out_xfer) begin
            if (corr_p2_q && corr_cnt_q != CNT_MAX) corr_cnt_d = corr_cnt_q + CNT_W'(1);
            if (unc_p2_q && unc_cnt_q != CNT_MAX)   unc_cnt_d  = unc_cnt_q + CNT_W'(1);
        end
    end

    // Error counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
        end else begin
            corr_cnt_q <= corr_cnt_d;
            unc_cnt_q  <= unc_cnt_d;
        end
    end
endmodule

// File: tb/tb_ham_secded_pipe.sv
// Testbench for ham_secded_pipe: a P=4/CNT_W=16 instance and a CNT_W=4 twin
// driven with identical stimulus; results are checked against a scoreboard of
// values derived from a reference encoder.
module tb_ham_secded_pipe;
    localparam int P = 4;
    localparam int N = 16;
    localparam int K = 11;

    typedef struct {
        logic [K-1:0] data;
        logic [P-1:0] syn;
        logic         corr;
        logic         unc;
        int           acc;
    } exp_t;

    logic clock;
    logic reset;

    ham_secded_pipe_if #(.P(P), .CNT_W(16)) bus ();
    ham_secded_pipe_if #(.P(P), .CNT_W(4))  bus4 ();

    assign bus4.in_valid     = bus.in_valid;
    assign bus4.code_in      = bus.code_in;
    assign bus4.out_ready    = bus.out_ready;
    assign bus4.clear_counts = bus.clear_counts;

    ham_secded_pipe #(.P(P), .CNT_W(16)) dut  (.clock(clock), .reset(reset), .bus(bus));
    ham_secded_pipe #(.P(P), .CNT_W(4))  dut4 (.clock(clock), .reset(reset), .bus(bus4));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t q[$];
    exp_t nxt;
    int   nassert = 0;
    int   nfail   = 0;
    int   cyc     = 0;
    bit   chk_lat = 1'b1;
    int   exp_c = 0, exp_u = 0, exp4_c = 0, exp4_u = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nassert++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic bit isdata(input int i);
        return (i != 0) && ((i & (i - 1)) != 0);
    endfunction

    // Data index of Hamming position i: i minus position 0 minus the powers of two <= i
    function automatic int didx(input int i);
        int l;
        l = 0;
        while ((1 << (l + 1)) <= i) l++;
        return i - 2 - l;
    endfunction

    // Reference encoder: place data, then each parity bit covers its index bit
    function automatic logic [N-1:0] enc(input logic [K-1:0] d);
        logic [N-1:0] c;
        logic         pb;
        int           j;
        c = '0;
        j = 0;
        for (int i = 1; i < N; i++) begin
            if (isdata(i)) begin
                c[i] = d[j];
                j++;
            end
        end
        for (int k = 0; k < P; k++) begin
            pb = 1'b0;
            for (int i = 1; i < N; i++) begin
                if (((i >> k) & 1) == 1) pb = pb ^ c[i];
            end
            c[1 << k] = pb;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic exp_t mk(input logic [K-1:0] d, input logic [P-1:0] s,
                                input logic c, input logic u);
        exp_t e;
        e.data = d; e.syn = s; e.corr = c; e.unc = u; e.acc = 0;
        return e;
    endfunction

    task automatic drive(input logic [N-1:0] code, input exp_t e);
        bus.in_valid = 1'b1;
        bus.code_in  = code;
        nxt          = e;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.code_in  = '0;
    endtask

    task automatic send_clean(input logic [K-1:0] d);
        drive(enc(d), mk(d, '0, 1'b0, 1'b0));
    endtask

    task automatic send_single(input logic [K-1:0] d, input int pos);
        logic [N-1:0] one;
        one = '0;
        one[pos] = 1'b1;
        drive(enc(d) ^ one, mk(d, P'(pos), 1'b1, 1'b0));
    endtask

    task automatic send_double(input logic [K-1:0] d, input int a, input int b);
        logic [N-1:0] two;
        logic [K-1:0] ed;
        two = '0;
        two[a] = 1'b1;
        two[b] = 1'b1;
        ed = d;
        if (isdata(a)) ed[didx(a)] = ~ed[didx(a)];
        if (isdata(b)) ed[didx(b)] = ~ed[didx(b)];
        drive(enc(d) ^ two, mk(ed, P'(a ^ b), 1'b0, 1'b1));
    endtask

    task automatic send_rand(input int kind);
        logic [K-1:0] d;
        int a;
        d = K'($urandom);
        a = $urandom_range(0, N - 1);
        if (kind == 0)      send_clean(d);
        else if (kind == 1) send_single(d, a);
        else                send_double(d, a, (a + $urandom_range(1, N - 1)) % N);
    endtask

    // One clock: sample handshakes at the falling edge, update scoreboard and
    // counter model, then check counters just after the rising edge
    task automatic tick();
        exp_t e;
        logic in_x, out_x, popped;
        popped = 1'b0;
        @(negedge clock);
        in_x  = bus.in_valid && bus.in_ready && !reset;
        out_x = bus.out_valid && bus.out_ready && !reset;
        if (out_x) begin
            chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                popped = 1'b1;
                chk("data_out", 32'(bus.data_out), 32'(e.data));
                chk("syndrome", 32'(bus.syndrome), 32'(e.syn));
                chk("corrected", 32'(bus.corrected), 32'(e.corr));
                chk("uncorrectable", 32'(bus.uncorrectable), 32'(e.unc));
                if (chk_lat) chk("latency", cyc - e.acc, 32'd2);
            end
        end
        if (bus.clear_counts) begin
            exp_c = 0; exp_u = 0; exp4_c = 0; exp4_u = 0;
        end else if (popped) begin
            if (e.corr) begin
                if (exp_c < 65535) exp_c++;
                if (exp4_c < 15)   exp4_c++;
            end
            if (e.unc) begin
                if (exp_u < 65535) exp_u++;
                if (exp4_u < 15)   exp4_u++;
            end
        end
        if (in_x) begin
            e = nxt;
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clock);
        cyc++;
        #1;
        chk("corr_count", 32'(bus.corr_count), exp_c);
        chk("uncorr_count", 32'(bus.uncorr_count), exp_u);
        chk("corr_count4", 32'(bus4.corr_count), exp4_c);
        chk("uncorr_count4", 32'(bus4.uncorr_count), exp4_u);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.code_in      = '0;
        bus.out_ready    = 1'b1;
        bus.clear_counts = 1'b0;
        nxt              = mk('0, '0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_data_out", 32'(bus.data_out), 0);
        chk("rst_syndrome", 32'(bus.syndrome), 0);
        chk("rst_corrected", 32'(bus.corrected), 0);
        chk("rst_uncorrectable", 32'(bus.uncorrectable), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid4", 32'(bus4.out_valid), 0);
        reset = 1'b0;
        tick();

        // Clean words back-to-back
        drive(16'h0000, mk(11'h000, 4'd0, 1'b0, 1'b0));
        chk("t1_in_ready0", 32'(bus.in_ready), 1);
        tick();
        drive(16'hFFFF, mk(11'h7FF, 4'd0, 1'b0, 1'b0));
        chk("t1_in_ready1", 32'(bus.in_ready), 1);
        tick();
        idle();
        chk("t1_in_ready2", 32'(bus.in_ready), 1);
        repeat (3) tick();

        // Single errors in a Hamming position and in bit 0
        drive(16'h0020, mk(11'h000, 4'd5, 1'b1, 1'b0));
        tick();
        drive(16'hFFFE, mk(11'h7FF, 4'd0, 1'b1, 1'b0));
        tick();
        idle();
        repeat (3) tick();
        chk("t2_corr_count", 32'(bus.corr_count), 2);

        // Double error
        drive(16'h0028, mk(11'h003, 4'd6, 1'b0, 1'b1));
        tick();
        idle();
        repeat (3) tick();
        chk("t3_uncorr_count", 32'(bus.uncorr_count), 1);
        chk("t3_corr_count", 32'(bus.corr_count), 2);

        // Mixed random words at full rate
        for (int i = 0; i < 24; i++) begin
            send_rand(i % 3);
            tick();
        end
        idle();
        repeat (3) tick();

        // Random backpressure and bubbles
        chk_lat = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) send_rand(i % 3);
            else idle();
            tick();
        end
        bus.out_ready = 1'b1;
        idle();
        repeat (4) tick();
        chk("rand_drained", 32'(q.size()), 0);

        // Stall: two words fill the pipe, third waits, outputs frozen
        bus.out_ready = 1'b0;
        send_single(11'h155, 9);
        tick();
        send_clean(11'h2AA);
        tick();
        send_double(11'h0F0, 3, 12);
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            chk("stall_out_valid", 32'(bus.out_valid), 1);
            chk("stall_data_out", 32'(bus.data_out), 32'(q[0].data));
            chk("stall_syndrome", 32'(bus.syndrome), 32'(q[0].syn));
            chk("stall_corrected", 32'(bus.corrected), 32'(q[0].corr));
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        idle();
        repeat (4) tick();
        chk("stall_drained", 32'(q.size()), 0);

        // Saturation: clear, then 20 corrected words
        chk_lat = 1'b1;
        bus.clear_counts = 1'b1;
        tick();
        bus.clear_counts = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send_single(K'($urandom), i % N);
            tick();
        end
        idle();
        repeat (3) tick();
        chk("sat_corr_count4", 32'(bus4.corr_count), 15);
        chk("sat_corr_count", 32'(bus.corr_count), 20);

        // Clear coinciding with a corrected-word transfer
        send_single(11'h3C3, 7);
        tick();
        idle();
        tick();
        chk("clr_pre_valid", 32'(bus.out_valid && bus.corrected), 1);
        bus.clear_counts = 1'b1;
        tick();
        bus.clear_counts = 1'b0;
        chk("clr_corr_count", 32'(bus.corr_count), 0);
        chk("clr_corr_count4", 32'(bus4.corr_count), 0);
        tick();

        // Reset mid-stream with two words in flight
        send_single(11'h011, 6);
        tick();
        send_single(11'h022, 10);
        tick();
        send_double(11'h044, 0, 13);
        tick();
        idle();
        chk("pre_rst_corr_count", 32'(bus.corr_count), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", 32'(bus.out_valid), 0);
        chk("rst_mid_corr_count", 32'(bus.corr_count), 0);
        chk("rst_mid_uncorr_count", 32'(bus.uncorr_count), 0);
        chk("rst_mid_in_ready", 32'(bus.in_ready), 1);
        q.delete();
        exp_c = 0; exp_u = 0; exp4_c = 0; exp4_u = 0;
        tick();
        tick();
        reset = 1'b0;
        send_clean(11'h5A5);
        tick();
        idle();
        repeat (4) tick();
        chk("final_drained", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule

// File: doc/ham_secded_pipe.md
Name: ham_secded_pipe

Overview:
- Parametrised successor to the Hamming(15,11) single-error fixer.
- Decodes an extended Hamming SECDED codeword of any width 2^P bits.
- Corrects single-bit errors, flags double-bit errors, and extracts the data bits.
- Runs as a 2-stage elastic pipeline with valid/ready handshakes and saturating error counters. It sits between a protected storage or link and its consumer.

Parameters:
- P, 4: Hamming parity-bit count, legal range 3..6. Derived: N = 2^P (codeword width), K = 2^P - 1 - P (data width); defaults give N=16, K=11.
- CNT_W, 16: width of each error counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  code_in is valid.
- in_ready  out  1  block accepts code_in this cycle.
- code_in  in  N  codeword. Bit 0 is the overall parity bit; bits 1..N-1 are Hamming positions, with parity bits at the power-of-two positions.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- data_out  out  K  corrected data: the non-power-of-two positions in ascending order, so position 3 maps to data_out[0].
- syndrome  out  P  syndrome of the word on the output.
- corrected  out  1  a single error was corrected (covers both Hamming positions and bit 0).
- uncorrectable  out  1  a double error was detected.
- clear_counts  in  1  synchronous clear of both counters.
- corr_count  out  CNT_W  saturating count of corrected words.
- uncorr_count  out  CNT_W  saturating count of uncorrectable words.

Behaviour:
- Reset (async, active-high): all valid flags 0; data_out, syndrome, corrected, uncorrectable and both counters 0. In-flight words are discarded and are never counted.
- Stage 1 registers code_in together with:
  - s = XOR of indices i (1..N-1) where code_in[i] = 1;
  - p = XOR of all N bits.
- Stage 2 registers the outputs:
  - s==0, p==0: no error; data passed through.
  - s!=0, p==1: flip bit s, then extract data; corrected=1.
  - s==0, p==1: bit 0 is in error; data unchanged; corrected=1.
  - s!=0, p==0: double error; data extracted uncorrected; uncorrectable=1.
  - syndrome output = s in all cases.
- Handshake:
  - A transfer occurs on valid && ready, on the rising clock edge.
  - Stage 2 loads when it is empty or when out_ready is high.
  - Stage 1 advances when stage 2 loads.
  - in_ready = !s1_valid || !s2_valid || out_ready (combinational, with no path from in_valid).
- Latency and throughput: 2 cycles from input acceptance to out_valid when there is no backpressure; 1 word per cycle sustained.
- Stall: while out_valid && !out_ready, every output is held stable and no word is lost or duplicated.
- Counters:
  - Increment only on an output transfer (out_valid && out_ready), when that word has corrected=1 or uncorrectable=1 respectively.
  - Saturate at 2^CNT_W - 1; there is no wrap.
  - clear_counts has priority: a simultaneous increment is dropped and the counter reads 0 on the next cycle.
- Outputs with out_valid=0 are don't-care, except the counters.

Test Plan (P=4, CNT_W=16 unless stated):
1. code_in 16'h0000, then 16'hFFFF, back-to-back with out_ready=1 -> two cycles later out_valid=1; data_out 11'h000 then 11'h7FF on consecutive cycles; syndrome 0; corrected=0 and uncorrectable=0 for both; in_ready stays 1.
2. code_in 16'h0020 (bit 5 flipped) -> data 11'h000, syndrome 5, corrected=1, corr_count=1. Then 16'hFFFE (bit 0 flipped) -> data 11'h7FF, syndrome 0, corrected=1, corr_count=2.
3. code_in 16'h0028 (bits 3 and 5 flipped) -> syndrome 6, uncorrectable=1, data_out 11'h003, uncorr_count=1, corr_count unchanged.
4. out_ready=0 with 3 words sent -> after 2 accepts, in_ready=0 and output held stable for 5 cycles. Then out_ready=1 -> all 3 words emerge in order with none dropped.
5. CNT_W=4, 20 single-error words -> corr_count saturates at 15. Then clear_counts asserted in the same cycle as a corrected-word transfer -> corr_count=0 next cycle.
6. reset asserted mid-stream with 2 words in flight -> out_valid=0 and counters 0 immediately. After release, the first new word appears 2 cycles after acceptance.
